// File: rtl/boot_loader_if.sv
// Byte-stream receive handshake plus program-memory write port of the boot loader.
// The master side feeds bytes and observes memory writes; the loader is the slave side.
interface boot_loader_if #(
  parameter int addr_width = 12,
  parameter int data_width = 16
) ();
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [addr_width-1:0] mem_address;
  logic [data_width-1:0] mem_data;
  logic                  mem_wren;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_address, mem_data, mem_wren
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/boot_loader.sv
// Serial boot loader: receives a length-prefixed, XOR-checksummed word stream,
// writes it to program memory and keeps the CPU held until a good load completes.
module boot_loader #(
  parameter int size       = 'h1000,
  parameter int addr_width = $clog2(size),
  parameter int data_width = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  boot_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [16:0] size_w = 17'(size);

  state_t                state_reg, state_next;
  logic [15:0]           len_reg, len_next;
  logic [16:0]           count_reg, count_next;
  logic [7:0]            csum_reg, csum_next;
  logic [7:0]            lo_reg, lo_next;
  logic [addr_width-1:0] mem_address_reg, mem_address_next;
  logic [data_width-1:0] mem_data_reg, mem_data_next;
  logic                  rx_ready_reg, mem_wren_reg;
  logic                  cpu_hold_reg, done_reg, error_reg;

  logic                  xfer;
  logic [15:0]           len_full;

  assign xfer     = bus.rx_valid && rx_ready_reg;
  assign len_full = {bus.rx_data, len_reg[7:0]};

  assign bus.rx_ready    = rx_ready_reg;
  assign bus.mem_wren    = mem_wren_reg;
  assign bus.mem_address = mem_address_reg;
  assign bus.mem_data    = mem_data_reg;
  assign cpu_hold        = cpu_hold_reg;
  assign done            = done_reg;
  assign error           = error_reg;

  always_comb begin
    state_next       = state_reg;
    len_next         = len_reg;
    count_next       = count_reg;
    csum_next        = csum_reg;
    lo_next          = lo_reg;
    mem_address_next = mem_address_reg;
    mem_data_next    = mem_data_reg;
    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_next = LEN_LO;
          count_next = '0;
          csum_next  = '0;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_next[7:0] = bus.rx_data;
          csum_next     = csum_reg ^ bus.rx_data;
          state_next    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_next  = len_full;
          csum_next = csum_reg ^ bus.rx_data;
          if ((len_full != 16'd0) && ({1'b0, len_full} <= size_w))
            state_next = DATA_LO;
          else
            state_next = ERROR;
        end
      end
      DATA_LO: begin
        if (xfer) begin
          lo_next    = bus.rx_data;
          csum_next  = csum_reg ^ bus.rx_data;
          state_next = DATA_HI;
        end
      end
      DATA_HI: begin
        // Memory outputs only move on entry to WRITE so they hold steady elsewhere.
        if (xfer) begin
          mem_data_next    = {bus.rx_data, lo_reg};
          mem_address_next = count_reg[addr_width-1:0];
          csum_next        = csum_reg ^ bus.rx_data;
          state_next       = WRITE;
        end
      end
      WRITE: begin
        count_next = count_reg + 17'd1;
        if ((count_reg + 17'd1) == {1'b0, len_reg})
          state_next = CHECK;
        else
          state_next = DATA_LO;
      end
      CHECK: begin
        if (xfer)
          state_next = (bus.rx_data == csum_reg) ? DONE : ERROR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered and glitch-free.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      len_reg         <= '0;
      count_reg       <= '0;
      csum_reg        <= '0;
      lo_reg          <= '0;
      mem_address_reg <= '0;
      mem_data_reg    <= '0;
      rx_ready_reg    <= 1'b0;
      mem_wren_reg    <= 1'b0;
      cpu_hold_reg    <= 1'b0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      len_reg         <= len_next;
      count_reg       <= count_next;
      csum_reg        <= csum_next;
      lo_reg          <= lo_next;
      mem_address_reg <= mem_address_next;
      mem_data_reg    <= mem_data_next;
      rx_ready_reg    <= (state_next == LEN_LO) || (state_next == LEN_HI) ||
                         (state_next == DATA_LO) || (state_next == DATA_HI) ||
                         (state_next == CHECK);
      mem_wren_reg    <= (state_next == WRITE);
      cpu_hold_reg    <= (state_next != IDLE) && (state_next != DONE);
      done_reg        <= (state_next == DONE);
      error_reg       <= (state_next == ERROR);
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: the driver queues expected memory writes,
// a negedge monitor pops and compares each mem_wren it observes.
module tb_boot_loader;

  logic clock;
  logic reset_n;
  logic start;
  logic cpu_hold, done, error;

  boot_loader_if #(.addr_width(12), .data_width(16)) bus ();

  boot_loader #(.size('h1000), .addr_width(12), .data_width(16)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus.slave),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;
  int wr_count   = 0;
  int cyc        = 0;
  int session    = 0;
  bit rate_on    = 0;
  logic [27:0] exp_q[$];
  logic [7:0]  tb_csum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the expectation queue.
  int mon_session = -1;
  int prev_cyc    = 0;
  always @(negedge clock) begin
    cyc++;
    if (bus.mem_wren === 1'b1) begin
      logic [27:0] e;
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {4'd0, bus.mem_address, bus.mem_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_addr_data", {4'd0, bus.mem_address, bus.mem_data}, {4'd0, e});
        $display("write @0x%03h = 0x%04h", bus.mem_address, bus.mem_data);
      end
      if (rate_on && mon_session == session)
        check("write_spacing", cyc - prev_cyc, 3);
      mon_session = session;
      prev_cyc    = cyc;
    end
  end

  // Present one byte, optionally after idle cycles; returns on the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    for (int i = 0; i < gap; i++) begin
      bus.rx_valid = 1'b0;
      @(negedge clock);
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tb_csum      = tb_csum ^ b;
    waited       = 0;
    while (bus.rx_ready !== 1'b1 && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 200) begin
      mismatched++;
      compared++;
      $display("FAIL rx_ready_timeout: got 0 expected 1 for byte 0x%02h", b);
    end
    @(negedge clock);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    tb_csum = 8'h00;
    session++;
  endtask

  task automatic send_word(input logic [11:0] addr, input logic [15:0] w, input int gap);
    send_byte(w[7:0], gap);
    exp_q.push_back({addr, w});
    send_byte(w[15:8], gap);
  endtask

  task automatic check_status(input string name, input logic [2:0] exp_hold_done_err);
    check(name, {29'd0, cpu_hold, done, error}, {29'd0, exp_hold_done_err});
  endtask

  function automatic logic [15:0] pattern(input int i);
    return 16'(16'hA5C3 ^ (i * 16'h0101) ^ (i << 4));
  endfunction

  initial begin
    int base;
    reset_n      = 1'b0;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    tb_csum      = 8'h00;
    repeat (3) @(negedge clock);

    // Reset state
    check("reset_outputs", {27'd0, bus.rx_ready, bus.mem_wren, cpu_hold, done, error}, 32'd0);
    check("reset_mem_bus", {4'd0, bus.mem_address, bus.mem_data}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check_status("idle_status", 3'b000);

    // Two-word load with good checksum, continuous rx_valid
    rate_on = 1;
    pulse_start();
    check("ready_after_start", {31'd0, bus.rx_ready}, 32'd1);
    check_status("hold_after_start", 3'b100);
    base = wr_count;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(12'h000, 16'h1234, 0);
    send_word(12'h001, 16'h5678, 0);
    check("csum_two_words", {24'd0, tb_csum}, 32'h0A);
    send_byte(tb_csum, 0);
    check_status("good_load_status", 3'b010);
    check("good_load_writes", wr_count - base, 2);
    check("good_load_queue", exp_q.size(), 0);
    rate_on = 0;

    // Same stream, checksum byte 00
    pulse_start();
    check_status("restart_clears_done", 3'b100);
    base = wr_count;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(12'h000, 16'h1234, 1);
    send_word(12'h001, 16'h5678, 0);
    send_byte(8'h00, 0);
    check_status("bad_csum_status", 3'b101);
    check("bad_csum_writes", wr_count - base, 2);

    // Length zero, then length 0x1001
    pulse_start();
    base = wr_count;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_status("len_zero_status", 3'b101);
    check("len_zero_ready", {31'd0, bus.rx_ready}, 32'd0);
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    check_status("len_over_status", 3'b101);
    repeat (3) @(negedge clock);
    check("len_error_writes", wr_count - base, 0);

    // Single word, N = 1
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(12'h000, 16'hCDAB, 0);
    send_byte(tb_csum, 0);
    check_status("single_word_status", 3'b010);

    // Full memory, random data and random rx_valid stalls
    pulse_start();
    base = wr_count;
    send_byte(8'h00, $urandom_range(0, 2));
    send_byte(8'h10, $urandom_range(0, 2));
    for (int i = 0; i < 4096; i++)
      send_word(12'(i), 16'($urandom_range(0, 65535)), $urandom_range(0, 1));
    send_byte(tb_csum, $urandom_range(0, 2));
    check_status("full_load_status", 3'b010);
    check("full_load_writes", wr_count - base, 4096);

    // Reset after 5 words of a 10-word load
    pulse_start();
    send_byte(8'h0A, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 5; i++) send_word(12'(i), pattern(i), 0);
    @(negedge clock);
    base = wr_count;
    reset_n = 1'b0;
    #1;
    check("midload_reset_outputs",
          {27'd0, bus.rx_ready, bus.mem_wren, cpu_hold, done, error}, 32'd0);
    check("midload_reset_mem_bus", {4'd0, bus.mem_address, bus.mem_data}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("midload_no_writes", wr_count - base, 0);
    check_status("midload_idle_status", 3'b000);

    // Fresh 10-word load at peak rate
    rate_on = 1;
    pulse_start();
    send_byte(8'h0A, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 10; i++) send_word(12'(i), pattern(i + 20), 0);
    send_byte(tb_csum, 0);
    check_status("reload_status", 3'b010);
    rate_on = 0;

    // start pulsed in DATA_HI is ignored
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_word(12'h000, 16'h1111, 0);
    send_byte(8'h22, 0);
    exp_q.push_back({12'h001, 16'h3322});
    start = 1'b1;
    send_byte(8'h33, 0);
    start = 1'b0;
    send_word(12'h002, 16'h5544, 0);
    send_byte(tb_csum, 0);
    check_status("start_in_data_hi_status", 3'b010);

    repeat (3) @(negedge clock);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
